level_unpacker_x4: RTL and testbench
====================================

# level_unpacker_x4

Upstream feeder for the four-lane dequantizer array. It accepts a valid/ready stream of packed 32-bit words of quantized weight levels plus per-level weight flags. Words are buffered in a small FIFO and unpacked into four sign-extended 32-bit levels per beat, with `is_weight` flags, on `level1..4` / `is_weight1..4`. It also produces a `deq_valid` strobe delayed to line up with the registered `weight_fp1..4` outputs of the dequantizer stage.

## Interface
- `LEVEL_W`, 8: level width in bits. Legal values are 8 (4 levels per word, 1 beat) and 4 (8 levels per word, 2 beats).
- `FIFO_DEPTH`, 4: input FIFO depth in words. Power of two, ≥2.
- `DEQ_LAT`, 1: dequantizer latency in cycles. Legal range 1..4.
- `TILE_WORDS`, 16: words per tile, ≥1.

Ports:
- `clk` input 1: clock; all logic is rising-edge.
- `rst` input 1: synchronous reset, active-low.
- `in_data` input 32: packed levels. Slot i occupies bits `[i*LEVEL_W +: LEVEL_W]`.
- `in_weight_mask` input 8: bit i is the weight flag for slot i. Only bits [3:0] are used when `LEVEL_W`=8.
- `in_valid` input 1: word present.
- `in_ready` output 1: FIFO can accept a word.
- `out_ready` input 1: downstream accepts the current beat.
- `out_valid` output 1: `level*` and `is_weight*` hold a valid beat.
- `level1`..`level4` output 32 each: sign-extended level for lanes 1..4.
- `is_weight1`..`is_weight4` output 1 each: lane weight flag.
- `out_tile_last` output 1: current beat is the final beat of a tile.
- `deq_valid` output 1: accepted beat delayed by `DEQ_LAT`; marks valid `weight_fp*`.
- `deq_tile_last` output 1: `out_tile_last` of the accepted beat, delayed by `DEQ_LAT`.

## Operation
- **FIFO push and in_ready:**
  - Push when `in_valid && in_ready`.
  - `in_ready = !full`, registered from the occupancy count.
  - When full, no push occurs even if a pop happens in the same cycle.
- **Pop:** a word is popped when the FIFO is non-empty and the output register is free (state EMPTY) or is retiring its last beat (`out_ready` high in LAST).
- **FSM states:**
  - EMPTY: no beat held.
  - FIRST: holding beat 0 of a 2-beat word (`LEVEL_W`=4 only).
  - LAST: holding the final beat of a word.
- **Transitions:**
  - Pop with `LEVEL_W`=8: go to LAST.
  - Pop with `LEVEL_W`=4: go to FIRST.
  - FIRST with `out_ready`: go to LAST.
  - LAST with `out_ready`: go to FIRST or LAST on a same-cycle pop, otherwise EMPTY.
- **Lane mapping, beat 0:** lane k (k=1..4) takes slot k-1, sign-extended to 32 bits. `is_weight`k = `in_weight_mask[k-1]`.
- **Lane mapping, beat 1 (`LEVEL_W`=4):** lane k takes slot k+3. `is_weight`k = `in_weight_mask[k+3]`.
- **Non-weight lanes:** the level value is still driven; only the flag is low.
- **Stall:** outputs hold stable while `out_valid && !out_ready`.
- **Tile counter:**
  - The word index counts popped words modulo `TILE_WORDS`.
  - `out_tile_last` is high on the final beat of word index `TILE_WORDS`-1.
  - The index wraps to 0 when that beat is accepted.
- **Delay line:** a `DEQ_LAT`-stage shift register of {accept, tile_last}, where accept = `out_valid && out_ready`. It shifts every cycle regardless of `out_ready`.

## Timing
- **Reset values (`rst` low at an edge):**
  - FIFO emptied, state EMPTY.
  - `in_ready`=0 during reset, 1 from the first cycle after `rst` rises.
  - `out_valid`=0, all `level*`=0, all `is_weight*`=0.
  - `out_tile_last`=0, tile index 0, delay line cleared, `deq_valid`=0, `deq_tile_last`=0.
- **Latency:** a word accepted at edge N with the FIFO empty and state EMPTY gives its first beat `out_valid`=1 in the cycle after edge N+1 (2 cycles).
- **Throughput:** sustained 1 beat/cycle with `out_ready` held high.
  - `LEVEL_W`=8: 1 word/cycle.
  - `LEVEL_W`=4: 1 word per 2 cycles; `in_ready` drops once the FIFO fills.
- **deq_valid:** high exactly `DEQ_LAT` cycles after the accept cycle.
- **Reset mid-operation:** buffered and held data are discarded; no `deq_valid` pulse for pre-reset beats.

## Configuration
- Macro `LVLPK_STATS_EN`.
- **Defined:** adds outputs `stat_beats` (32-bit count of accepted beats) and `stat_stalls` (32-bit count of cycles with `out_valid && !out_ready`). Both wrap at 2^32 and reset to 0.
- **Undefined:** ports and counters are absent; all other behaviour is identical.

## Test plan
- **Single word:** reset, `LEVEL_W`=8, push `in_data`=0x80FF017F, mask=0x5 → two cycles later `level1`=0x0000007F, `level2`=0x00000001, `level3`=0xFFFFFFFF, `level4`=0xFFFFFF80; `is_weight1..4`=1,0,1,0; `deq_valid` high `DEQ_LAT` cycles after the accept.
- **Two-beat unpack:** `LEVEL_W`=4, push 0x8765F10E, mask=0xF0 → beat 0 lanes 0xFFFFFFFE, 0x00000000, 0x00000001, 0xFFFFFFFF with flags 0; beat 1 lanes 0x00000005, 0x00000006, 0x00000007, 0xFFFFFFF8 with flags 1.
- **Backpressure:** hold `out_ready` low and push 5 words with `FIFO_DEPTH`=4 → `in_ready` falls after 4 pushes beyond the held beat; outputs stay stable; no word is lost or duplicated once `out_ready` rises.
- **Tile wrap:** with `TILE_WORDS`=3, stream 7 words → `out_tile_last` on words 3 and 6 only; `deq_tile_last` follows after `DEQ_LAT`.
- **Reset mid-operation:** pull `rst` low with the FIFO full and a beat held → next cycle `out_valid`=0, `deq_valid` stays 0, `in_ready`=1 after release; the first post-reset word emerges with tile index 0.

Source files
------------

// File: rtl/level_unpacker_x4.sv
// level_unpacker_x4: buffers packed level words and unpacks them into four sign-extended lanes.
// Optional statistics outputs (stat_beats, stat_stalls) are enabled by defining LVLPK_STATS_EN.
module level_unpacker_x4 #(
  parameter int unsigned LEVEL_W    = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DEQ_LAT    = 1,
  parameter int unsigned TILE_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic [7:0]  in_weight_mask,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] level1,
  output logic [31:0] level2,
  output logic [31:0] level3,
  output logic [31:0] level4,
  output logic        is_weight1,
  output logic        is_weight2,
  output logic        is_weight3,
  output logic        is_weight4,
  output logic        out_tile_last,
  output logic        deq_valid,
  output logic        deq_tile_last
`ifdef LVLPK_STATS_EN
  ,
  output logic [31:0] stat_beats,
  output logic [31:0] stat_stalls
`endif
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TILE_WORDS + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TILE_MAX   = TW'(TILE_WORDS - 1);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_FIRST,
    S_LAST
  } state_t;

  state_t          state;
  logic [31:0]     fifo_data [FIFO_DEPTH];
  logic [7:0]      fifo_mask [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic            push;
  logic            pop;
  logic            accept;
  logic [31:0]     head_data;
  logic [7:0]      head_mask;

  logic [31:0]     lvl [4];
  logic [3:0]      flag;
  logic [31:0]     hold_data;
  logic [3:0]      hold_mask;
  logic            hold_last;
  logic [TW-1:0]   word_idx;

  logic [DEQ_LAT-1:0] dv;
  logic [DEQ_LAT-1:0] dl;

  function automatic logic [31:0] lane(input logic [31:0] word, input logic [2:0] slot);
    logic [4:0]         base;
    logic [LEVEL_W-1:0] v;
    base = 5'(slot * LEVEL_W);
    v    = word[base +: LEVEL_W];
    return {{(32 - LEVEL_W){v[LEVEL_W-1]}}, v};
  endfunction

  always_comb begin
    push       = in_valid && in_ready;
    pop        = (count != '0) && ((state == S_EMPTY) || (state == S_LAST && out_ready));
    accept     = out_valid && out_ready;
    count_next = count + CW'(push) - CW'(pop);
    head_data  = fifo_data[rd_ptr];
    head_mask  = fifo_mask[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= in_data;
      fifo_mask[wr_ptr] <= in_weight_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_next;
      in_ready <= (count_next != FULL_COUNT);
    end
  end

  // A pop while retiring the last beat reloads the output register in the same cycle,
  // which is what sustains one beat per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_EMPTY;
      out_valid     <= 1'b0;
      out_tile_last <= 1'b0;
      for (int unsigned k = 0; k < 4; k++) lvl[k] <= '0;
      flag          <= '0;
      hold_data     <= '0;
      hold_mask     <= '0;
      hold_last     <= 1'b0;
      word_idx      <= '0;
    end else if (pop) begin
      for (int unsigned k = 0; k < 4; k++) lvl[k] <= lane(head_data, 3'(k));
      flag      <= head_mask[3:0];
      hold_data <= head_data;
      hold_mask <= head_mask[7:4];
      out_valid <= 1'b1;
      word_idx  <= (word_idx == TILE_MAX) ? '0 : word_idx + 1'b1;
      if (LEVEL_W == 4) begin
        state         <= S_FIRST;
        out_tile_last <= 1'b0;
        hold_last     <= (word_idx == TILE_MAX);
      end else begin
        state         <= S_LAST;
        out_tile_last <= (word_idx == TILE_MAX);
      end
    end else if (state == S_FIRST && out_ready) begin
      for (int unsigned k = 0; k < 4; k++) lvl[k] <= lane(hold_data, 3'(k + 4));
      flag          <= hold_mask;
      out_tile_last <= hold_last;
      state         <= S_LAST;
    end else if (state == S_LAST && out_ready) begin
      state         <= S_EMPTY;
      out_valid     <= 1'b0;
      out_tile_last <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dv <= '0;
      dl <= '0;
    end else begin
      dv[0] <= accept;
      dl[0] <= accept && out_tile_last;
      for (int unsigned i = 1; i < DEQ_LAT; i++) begin
        dv[i] <= dv[i-1];
        dl[i] <= dl[i-1];
      end
    end
  end

  assign level1        = lvl[0];
  assign level2        = lvl[1];
  assign level3        = lvl[2];
  assign level4        = lvl[3];
  assign is_weight1    = flag[0];
  assign is_weight2    = flag[1];
  assign is_weight3    = flag[2];
  assign is_weight4    = flag[3];
  assign deq_valid     = dv[DEQ_LAT-1];
  assign deq_tile_last = dl[DEQ_LAT-1];

`ifdef LVLPK_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_beats  <= '0;
      stat_stalls <= '0;
    end else begin
      if (accept)                  stat_beats  <= stat_beats + 1'b1;
      if (out_valid && !out_ready) stat_stalls <= stat_stalls + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_level_unpacker_x4.sv
// Directed bench: dut_a is the one-beat (LEVEL_W=8) build, dut_b the two-beat (LEVEL_W=4) build.
module tb_level_unpacker_x4;

  logic clk;
  logic rst;

  logic [31:0] a_in_data, b_in_data;
  logic [7:0]  a_in_mask, b_in_mask;
  logic        a_in_valid, b_in_valid;
  logic        a_in_ready, b_in_ready;
  logic        a_out_ready, b_out_ready;
  logic        a_out_valid, b_out_valid;
  logic [31:0] a_l1, a_l2, a_l3, a_l4;
  logic [31:0] b_l1, b_l2, b_l3, b_l4;
  logic        a_w1, a_w2, a_w3, a_w4;
  logic        b_w1, b_w2, b_w3, b_w4;
  logic        a_tile_last, b_tile_last;
  logic        a_deq_valid, b_deq_valid;
  logic        a_deq_last, b_deq_last;
`ifdef LVLPK_STATS_EN
  logic [31:0] a_stat_beats, a_stat_stalls, b_stat_beats, b_stat_stalls;
`endif

  int vectors = 0;
  int miscompares = 0;

  level_unpacker_x4 #(.LEVEL_W(8), .FIFO_DEPTH(4), .DEQ_LAT(2), .TILE_WORDS(3)) dut_a (
    .clk(clk), .rst(rst),
    .in_data(a_in_data), .in_weight_mask(a_in_mask), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_ready(a_out_ready), .out_valid(a_out_valid),
    .level1(a_l1), .level2(a_l2), .level3(a_l3), .level4(a_l4),
    .is_weight1(a_w1), .is_weight2(a_w2), .is_weight3(a_w3), .is_weight4(a_w4),
    .out_tile_last(a_tile_last), .deq_valid(a_deq_valid), .deq_tile_last(a_deq_last)
`ifdef LVLPK_STATS_EN
    , .stat_beats(a_stat_beats), .stat_stalls(a_stat_stalls)
`endif
  );

  level_unpacker_x4 #(.LEVEL_W(4), .FIFO_DEPTH(4), .DEQ_LAT(1), .TILE_WORDS(2)) dut_b (
    .clk(clk), .rst(rst),
    .in_data(b_in_data), .in_weight_mask(b_in_mask), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_ready(b_out_ready), .out_valid(b_out_valid),
    .level1(b_l1), .level2(b_l2), .level3(b_l3), .level4(b_l4),
    .is_weight1(b_w1), .is_weight2(b_w2), .is_weight3(b_w3), .is_weight4(b_w4),
    .out_tile_last(b_tile_last), .deq_valid(b_deq_valid), .deq_tile_last(b_deq_last)
`ifdef LVLPK_STATS_EN
    , .stat_beats(b_stat_beats), .stat_stalls(b_stat_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    a_in_data = '0; a_in_mask = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_in_data = '0; b_in_mask = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;

    // reset state
    tick(); tick(); tick();
    chk("rst_a_in_ready", 32'(a_in_ready), 32'd0);
    chk("rst_b_in_ready", 32'(b_in_ready), 32'd0);
    chk("rst_a_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_a_level1", a_l1, 32'h0);
    chk("rst_a_flags", 32'({a_w4, a_w3, a_w2, a_w1}), 32'h0);
    chk("rst_a_deq_valid", 32'(a_deq_valid), 32'd0);
    chk("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    rst = 1'b1;
    tick();
    chk("rel_a_in_ready", 32'(a_in_ready), 32'd1);
    chk("rel_b_in_ready", 32'(b_in_ready), 32'd1);

    // single word, one beat
    a_in_data = 32'h80FF017F; a_in_mask = 8'h05; a_in_valid = 1'b1; a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0;
    chk("sw_not_yet_valid", 32'(a_out_valid), 32'd0);
    tick();
    chk("sw_out_valid", 32'(a_out_valid), 32'd1);
    chk("sw_level1", a_l1, 32'h0000007F);
    chk("sw_level2", a_l2, 32'h00000001);
    chk("sw_level3", a_l3, 32'hFFFFFFFF);
    chk("sw_level4", a_l4, 32'hFFFFFF80);
    chk("sw_flags", 32'({a_w4, a_w3, a_w2, a_w1}), 32'h5);
    chk("sw_tile_last", 32'(a_tile_last), 32'd0);
    tick();
    chk("sw_retired", 32'(a_out_valid), 32'd0);
    chk("sw_deq_early", 32'(a_deq_valid), 32'd0);
    tick();
    chk("sw_deq_valid", 32'(a_deq_valid), 32'd1);
    tick();
    chk("sw_deq_drop", 32'(a_deq_valid), 32'd0);

    // two-beat unpack with a stall on beat 0
    b_in_data = 32'h8765F10E; b_in_mask = 8'hF0; b_in_valid = 1'b1; b_out_ready = 1'b0;
    tick();
    b_in_valid = 1'b0;
    tick();
    chk("tb_b0_valid", 32'(b_out_valid), 32'd1);
    chk("tb_b0_level1", b_l1, 32'hFFFFFFFE);
    chk("tb_b0_level2", b_l2, 32'h00000000);
    chk("tb_b0_level3", b_l3, 32'h00000001);
    chk("tb_b0_level4", b_l4, 32'hFFFFFFFF);
    chk("tb_b0_flags", 32'({b_w4, b_w3, b_w2, b_w1}), 32'h0);
    tick();
    chk("tb_stall_valid", 32'(b_out_valid), 32'd1);
    chk("tb_stall_level1", b_l1, 32'hFFFFFFFE);
    chk("tb_stall_deq", 32'(b_deq_valid), 32'd0);
    b_out_ready = 1'b1;
    tick();
    chk("tb_b1_level1", b_l1, 32'h00000005);
    chk("tb_b1_level2", b_l2, 32'h00000006);
    chk("tb_b1_level3", b_l3, 32'h00000007);
    chk("tb_b1_level4", b_l4, 32'hFFFFFFF8);
    chk("tb_b1_flags", 32'({b_w4, b_w3, b_w2, b_w1}), 32'hF);
    chk("tb_b1_tile_last", 32'(b_tile_last), 32'd0);
    chk("tb_b0_deq", 32'(b_deq_valid), 32'd1);
    tick();
    chk("tb_retired", 32'(b_out_valid), 32'd0);
    chk("tb_b1_deq", 32'(b_deq_valid), 32'd1);
    tick();
    chk("tb_deq_drop", 32'(b_deq_valid), 32'd0);

    // second two-beat word closes dut_b's tile of 2 words
    b_in_data = 32'h12345678; b_in_mask = 8'h0F; b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    tick();
    chk("tb2_b0_level1", b_l1, 32'hFFFFFFF8);
    chk("tb2_b0_flags", 32'({b_w4, b_w3, b_w2, b_w1}), 32'hF);
    chk("tb2_b0_tile_last", 32'(b_tile_last), 32'd0);
    tick();
    chk("tb2_b1_level1", b_l1, 32'h00000004);
    chk("tb2_b1_flags", 32'({b_w4, b_w3, b_w2, b_w1}), 32'h0);
    chk("tb2_b1_tile_last", 32'(b_tile_last), 32'd1);
    tick();
    chk("tb2_deq_tile_last", 32'(b_deq_last), 32'd1);

    // backpressure: five words into a depth-4 FIFO with the output stalled
    a_out_ready = 1'b0;
    a_in_valid = 1'b1;
    a_in_data = 32'hF0203001; tick();
    a_in_data = 32'hF0203002; tick();
    a_in_data = 32'hF0203003; tick();
    a_in_data = 32'hF0203004; tick();
    a_in_data = 32'hF0203005; tick();
    a_in_valid = 1'b0;
    chk("bp_in_ready_low", 32'(a_in_ready), 32'd0);
    chk("bp_held_valid", 32'(a_out_valid), 32'd1);
    chk("bp_held_level1", a_l1, 32'h00000001);
    chk("bp_held_level4", a_l4, 32'hFFFFFFF0);
    tick(); tick();
    chk("bp_stable_level1", a_l1, 32'h00000001);
    chk("bp_stable_in_ready", 32'(a_in_ready), 32'd0);
    chk("bp_no_deq", 32'(a_deq_valid), 32'd0);
    a_out_ready = 1'b1;
    tick();
    chk("bp_w1_level1", a_l1, 32'h00000002);
    chk("bp_w1_tile_last", 32'(a_tile_last), 32'd1);
    chk("bp_in_ready_back", 32'(a_in_ready), 32'd1);
    tick();
    chk("bp_w2_level1", a_l1, 32'h00000003);
    chk("bp_w2_tile_last", 32'(a_tile_last), 32'd0);
    tick();
    chk("bp_w3_level1", a_l1, 32'h00000004);
    chk("bp_w3_tile_last", 32'(a_tile_last), 32'd0);
    chk("bp_w1_deq_valid", 32'(a_deq_valid), 32'd1);
    chk("bp_w1_deq_tile_last", 32'(a_deq_last), 32'd1);
    tick();
    chk("bp_w4_level1", a_l1, 32'h00000005);
    chk("bp_w4_tile_last", 32'(a_tile_last), 32'd1);
    chk("bp_w2_deq_tile_last", 32'(a_deq_last), 32'd0);
    tick();
    chk("bp_drained", 32'(a_out_valid), 32'd0);
    tick();
    chk("bp_w4_deq_tile_last", 32'(a_deq_last), 32'd1);
    tick();
    chk("bp_deq_idle", 32'(a_deq_valid), 32'd0);

    // reset with the FIFO full and a beat held; tile index was 1 before reset
    a_out_ready = 1'b0;
    a_in_valid = 1'b1;
    a_in_data = 32'h00000011; tick();
    a_in_data = 32'h00000012; tick();
    a_in_data = 32'h00000013; tick();
    a_in_data = 32'h00000014; tick();
    a_in_data = 32'h00000015; tick();
    a_in_valid = 1'b0;
    chk("mr_full", 32'(a_in_ready), 32'd0);
    rst = 1'b0;
    a_out_ready = 1'b1;
    tick();
    chk("mr_out_valid", 32'(a_out_valid), 32'd0);
    chk("mr_in_ready_in_reset", 32'(a_in_ready), 32'd0);
    chk("mr_deq_in_reset", 32'(a_deq_valid), 32'd0);
    rst = 1'b1;
    tick();
    chk("mr_in_ready_after", 32'(a_in_ready), 32'd1);
    chk("mr_deq_after", 32'(a_deq_valid), 32'd0);
    chk("mr_fifo_flushed", 32'(a_out_valid), 32'd0);
    tick();
    chk("mr_deq_after2", 32'(a_deq_valid), 32'd0);
    chk("mr_still_empty", 32'(a_out_valid), 32'd0);

    a_in_valid = 1'b1;
    a_in_data = 32'h0000007A; tick();
    a_in_data = 32'h0000007B; tick();
    chk("mr_x0_level1", a_l1, 32'h0000007A);
    chk("mr_x0_tile_last", 32'(a_tile_last), 32'd0);
    a_in_data = 32'h0000007C; tick();
    a_in_valid = 1'b0;
    chk("mr_x1_level1", a_l1, 32'h0000007B);
    chk("mr_x1_tile_last", 32'(a_tile_last), 32'd0);
    tick();
    chk("mr_x2_level1", a_l1, 32'h0000007C);
    chk("mr_x2_tile_last", 32'(a_tile_last), 32'd1);
    tick();
    chk("mr_end_idle", 32'(a_out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
